// File: rtl/iob_post_fifo_if.sv
// IOB request channel between the post FIFO (slave) and the IOB master.
// IOREQ/IOACT handshake plus the head-entry fields and returned read data.
interface iob_post_fifo_if #(
    parameter int AW = 23,
    parameter int DW = 16
) ();
    logic          IOREQ;
    logic          IOACT;
    logic          IORW0;
    logic          IOL0;
    logic          IOU0;
    logic [AW:1]   IOA;
    logic [DW-1:0] IOD;
    logic [DW-1:0] IODIN;

    modport slave (
        output IOREQ, IORW0, IOL0, IOU0, IOA, IOD,
        input  IOACT, IODIN
    );

    modport master (
        input  IOREQ, IORW0, IOL0, IOU0, IOA, IOD,
        output IOACT, IODIN
    );
endinterface

// File: rtl/iob_post_fifo.sv
// FSB-to-IOB in-order transfer FIFO with optional write posting.
// Define IOB_POST_WRITE_EN to let writes retire as soon as they are queued.
module iob_post_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 23,
    parameter int DW    = 16
) (
    input  logic          CLK_FSB,
    input  logic          nRES,
    input  logic [AW:1]   A_FSB,
    input  logic [DW-1:0] D_FSB,
    input  logic          nWE_FSB,
    input  logic          nLDS_FSB,
    input  logic          nUDS_FSB,
    input  logic          ASActive,
    input  logic          ASInactive,
    input  logic          IOCS,
    output logic          Ready_IOBS,
    output logic          nDinOE,
    output logic [DW-1:0] RDATA,
    output logic          IOEmpty,
    iob_post_fifo_if.slave iob
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef IOB_POST_WRITE_EN
    localparam bit POST = 1'b1;
`else
    localparam bit POST = 1'b0;
`endif

    typedef struct packed {
        logic          rw;
        logic          l;
        logic          u;
        logic [AW:1]   a;
        logic [DW-1:0] d;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY} sst_t;
    typedef enum logic [1:0] {M_IDLE, M_REQ, M_ACT} mst_t;

    ent_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    sst_t          sst_q, sst_d;
    mst_t          mst_q, mst_d;
    ent_t          cur_q, cur_d;
    logic          pend_q, pend_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] rdata_q;

    ent_t new_ent, head, push_ent;
    logic full, empty, push, pop, rd_done, done;
    logic aborted, m_busy;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rptr_q];
    assign pop     = (mst_q == M_ACT) & ~iob.IOACT;
    assign rd_done = pop & head.rw;
    // Non-posted cycles finish on their own pop; occupancy is at most one.
    assign done    = POST ? rd_done : pop;
    assign aborted = abort_q | ASInactive;

    assign new_ent = '{
        rw: nWE_FSB,
        l:  ~nLDS_FSB,
        u:  ~nUDS_FSB,
        a:  A_FSB,
        d:  D_FSB
    };

    always_comb begin
        sst_d    = sst_q;
        cur_d    = cur_q;
        pend_d   = pend_q;
        abort_d  = abort_q;
        push     = 1'b0;
        push_ent = cur_q;
        unique case (sst_q)
            S_IDLE: begin
                if (ASActive & IOCS) begin
                    cur_d   = new_ent;
                    abort_d = 1'b0;
                    sst_d   = S_WAIT;
                    if (!full) begin
                        push     = 1'b1;
                        push_ent = new_ent;
                        if (!new_ent.rw && POST)
                            sst_d = S_RDY;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (ASInactive)
                    abort_d = 1'b1;
                if (pend_q) begin
                    if (!full) begin
                        push   = 1'b1;
                        pend_d = 1'b0;
                        if (!cur_q.rw && POST)
                            sst_d = aborted ? S_IDLE : S_RDY;
                    end
                end else if (done) begin
                    sst_d = aborted ? S_IDLE : S_RDY;
                end
            end
            S_RDY: begin
                if (ASInactive)
                    sst_d = S_IDLE;
            end
            default: sst_d = S_IDLE;
        endcase
    end

    always_comb begin
        mst_d = mst_q;
        unique case (mst_q)
            M_IDLE:  if (!empty) mst_d = M_REQ;
            M_REQ:   if (iob.IOACT) mst_d = M_ACT;
            M_ACT:   if (!iob.IOACT) mst_d = M_IDLE;
            default: mst_d = M_IDLE;
        endcase
    end

    always_ff @(posedge CLK_FSB or negedge nRES) begin
        if (!nRES) begin
            sst_q   <= S_IDLE;
            mst_q   <= M_IDLE;
            cur_q   <= '0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            sst_q   <= sst_d;
            mst_q   <= mst_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            if (rd_done)
                rdata_q <= iob.IODIN;
        end
    end

    // Storage needs no reset: the head is gated off while the master idles.
    always_ff @(posedge CLK_FSB) begin
        if (push)
            mem_q[wptr_q] <= push_ent;
    end

    assign m_busy     = (mst_q != M_IDLE);
    assign iob.IOREQ  = (mst_q == M_REQ);
    assign iob.IORW0  = m_busy & head.rw;
    assign iob.IOL0   = m_busy & head.l;
    assign iob.IOU0   = m_busy & head.u;
    assign iob.IOA    = m_busy ? head.a : '0;
    assign iob.IOD    = m_busy ? head.d : '0;

    assign Ready_IOBS = ~IOCS | (sst_q == S_RDY);
    assign nDinOE     = ~((sst_q == S_RDY) & cur_q.rw);
    assign RDATA      = rdata_q;
    assign IOEmpty    = empty & ~m_busy;
endmodule

// File: tb/tb_iob_post_fifo.sv
// Directed bench for iob_post_fifo: vector table plus handshake sequences.
// Covers both the posted and non-posted builds of IOB_POST_WRITE_EN.
module tb_iob_post_fifo;
  localparam int AW = 23;
  localparam int DW = 16;
`ifdef IOB_POST_WRITE_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic clk = 1'b0;
  logic nres;
  logic [AW:1] a;
  logic [DW-1:0] d;
  logic nwe, nlds, nuds;
  logic asa, asi, iocs;
  logic rdy, ndoe, ioempty;
  logic [DW-1:0] rdata;

  iob_post_fifo_if #(.AW(AW), .DW(DW)) io ();

  iob_post_fifo #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .CLK_FSB   (clk),
    .nRES      (nres),
    .A_FSB     (a),
    .D_FSB     (d),
    .nWE_FSB   (nwe),
    .nLDS_FSB  (nlds),
    .nUDS_FSB  (nuds),
    .ASActive  (asa),
    .ASInactive(asi),
    .IOCS      (iocs),
    .Ready_IOBS(rdy),
    .nDinOE    (ndoe),
    .RDATA     (rdata),
    .IOEmpty   (ioempty),
    .iob       (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          nwe;
    logic [AW:1]   a;
    logic [DW-1:0] d;
    logic          nlds;
    logic          nuds;
    logic [DW-1:0] din;
    logic          e_rw;
    logic          e_l;
    logic          e_u;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fsb_start(input logic w_n, input logic [AW:1] aa,
                           input logic [DW-1:0] dd);
    iocs = 1'b1;
    a    = aa;
    d    = dd;
    nwe  = w_n;
    nlds = 1'b0;
    nuds = 1'b0;
    asa  = 1'b1;
    tick();
    asa  = 1'b0;
  endtask

  task automatic fsb_end();
    asi = 1'b1;
    tick();
    asi  = 1'b0;
    iocs = 1'b0;
    #1;
  endtask

  task automatic serve(input logic [DW-1:0] din);
    io.IOACT = 1'b1;
    tick();
    io.IOACT = 1'b0;
    io.IODIN = din;
    tick();
  endtask

  task automatic do_xfer(input vec_t v, input int i);
    logic early;
    early = POST && !v.nwe;
    iocs  = 1'b1;
    a     = v.a;
    d     = v.d;
    nwe   = v.nwe;
    nlds  = v.nlds;
    nuds  = v.nuds;
    asa   = 1'b1;
    #1 chk($sformatf("v%0d_rdy_pre", i), rdy, 0);
    tick();
    asa = 1'b0;
    chk($sformatf("v%0d_rdy_as", i), rdy, early);
    chk($sformatf("v%0d_empty_busy", i), ioempty, 0);
    tick();
    chk($sformatf("v%0d_ioreq", i), io.IOREQ, 1);
    chk($sformatf("v%0d_ioa", i), io.IOA, v.a);
    chk($sformatf("v%0d_iod", i), io.IOD, v.d);
    chk($sformatf("v%0d_iorw", i), io.IORW0, v.e_rw);
    chk($sformatf("v%0d_iol", i), io.IOL0, v.e_l);
    chk($sformatf("v%0d_iou", i), io.IOU0, v.e_u);
    chk($sformatf("v%0d_rdy_req", i), rdy, early);
    io.IOACT = 1'b1;
    tick();
    chk($sformatf("v%0d_ioreq_act", i), io.IOREQ, 0);
    chk($sformatf("v%0d_ioa_act", i), io.IOA, v.a);
    chk($sformatf("v%0d_rdy_act", i), rdy, early);
    io.IOACT = 1'b0;
    io.IODIN = v.din;
    tick();
    chk($sformatf("v%0d_rdy_done", i), rdy, 1);
    chk($sformatf("v%0d_ndoe", i), ndoe, !v.e_rw);
    chk($sformatf("v%0d_rdata", i), rdata, v.e_rdata);
    chk($sformatf("v%0d_empty", i), ioempty, 1);
    fsb_end();
    chk($sformatf("v%0d_ndoe_end", i), ndoe, 1);
    chk($sformatf("v%0d_rdy_end", i), rdy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 23'h0F0000, 16'h1234, 1'b0, 1'b0, 16'hDEAD,
                1'b0, 1'b1, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 23'h0F0010, 16'h0000, 1'b0, 1'b1, 16'hA5C3,
                1'b1, 1'b1, 1'b0, 16'hA5C3};
    vecs[2] = '{1'b0, 23'h7FFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h5A5A,
                1'b0, 1'b0, 1'b1, 16'hA5C3};
    vecs[3] = '{1'b1, 23'h000001, 16'h0000, 1'b1, 1'b0, 16'h0F0F,
                1'b1, 1'b0, 1'b1, 16'h0F0F};

    nres = 1'b0;
    a = '0; d = '0;
    nwe = 1'b1; nlds = 1'b1; nuds = 1'b1;
    asa = 1'b0; asi = 1'b0; iocs = 1'b0;
    io.IOACT = 1'b0;
    io.IODIN = '0;
    tick();
    tick();
    nres = 1'b1;
    tick();
    chk("rst_rdy", rdy, 1);
    chk("rst_ndoe", ndoe, 1);
    chk("rst_ioreq", io.IOREQ, 0);
    chk("rst_empty", ioempty, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_ioa", io.IOA, 0);
    chk("rst_iod", io.IOD, 0);
    chk("rst_iorw", io.IORW0, 0);

    for (int i = 0; i < 4; i++)
      do_xfer(vecs[i], i);

    if (POST) begin
      // Two posted writes fill the FIFO; the third stalls.
      fsb_start(1'b0, 23'h0F0000, 16'h0001);
      chk("p_w0_rdy", rdy, 1);
      fsb_end();
      fsb_start(1'b0, 23'h0F0002, 16'h0002);
      chk("p_w1_rdy", rdy, 1);
      fsb_end();
      chk("p_full_ioreq", io.IOREQ, 1);
      chk("p_full_ioa", io.IOA, 23'h0F0000);
      fsb_start(1'b0, 23'h0F0004, 16'h0003);
      chk("p_w2_stall0", rdy, 0);
      tick();
      chk("p_w2_stall1", rdy, 0);
      chk("p_head_stable", io.IOA, 23'h0F0000);
      serve(16'h0000);
      chk("p_stall_P1", rdy, 0);
      tick();
      chk("p_stall_P2", rdy, 1);
      chk("p_ord1_req", io.IOREQ, 1);
      chk("p_ord1_ioa", io.IOA, 23'h0F0002);
      fsb_end();
      serve(16'h0000);
      tick();
      chk("p_ord2_ioa", io.IOA, 23'h0F0004);
      serve(16'h0000);
      chk("p_drain_empty", ioempty, 1);

      // Read queued behind two posted writes.
      fsb_start(1'b0, 23'h0F0020, 16'h0011);
      fsb_end();
      fsb_start(1'b0, 23'h0F0022, 16'h0022);
      fsb_end();
      fsb_start(1'b1, 23'h0F0030, 16'h0000);
      chk("r_rdy0", rdy, 0);
      serve(16'h0000);
      tick();
      chk("r_rdy1", rdy, 0);
      chk("r_ioa1", io.IOA, 23'h0F0022);
      serve(16'h0000);
      tick();
      chk("r_rdy2", rdy, 0);
      chk("r_ioa2", io.IOA, 23'h0F0030);
      chk("r_iorw2", io.IORW0, 1);
      io.IOACT = 1'b1;
      tick();
      chk("r_rdy_act", rdy, 0);
      io.IOACT = 1'b0;
      io.IODIN = 16'hA5C3;
      tick();
      chk("r_rdy_done", rdy, 1);
      chk("r_ndoe", ndoe, 0);
      chk("r_rdata", rdata, 16'hA5C3);
      tick();
      chk("r_ndoe_hold", ndoe, 0);
      fsb_end();
      chk("r_ndoe_end", ndoe, 1);

      // Push and pop on the same edge at count 1, twice.
      fsb_start(1'b0, 23'h0F0050, 16'h0050);
      chk("s_w0_rdy", rdy, 1);
      fsb_end();
      chk("s_w0_ioa", io.IOA, 23'h0F0050);
      io.IOACT = 1'b1;
      tick();
      io.IOACT = 1'b0;
      fsb_start(1'b0, 23'h0F0052, 16'h0052);
      chk("s_w1_rdy", rdy, 1);
      chk("s_cnt1_a", ioempty, 0);
      fsb_end();
      chk("s_w1_req", io.IOREQ, 1);
      chk("s_w1_ioa", io.IOA, 23'h0F0052);
      io.IOACT = 1'b1;
      tick();
      io.IOACT = 1'b0;
      fsb_start(1'b0, 23'h0F0054, 16'h0054);
      chk("s_cnt1_b", ioempty, 0);
      fsb_end();
      chk("s_w2_ioa", io.IOA, 23'h0F0054);
      chk("s_w2_iod", io.IOD, 16'h0054);
      serve(16'h0000);
      chk("s_empty", ioempty, 1);

      // Two entries queued, master mid-transfer.
      fsb_start(1'b0, 23'h0F0060, 16'h0060);
      fsb_end();
      fsb_start(1'b0, 23'h0F0062, 16'h0062);
      fsb_end();
      io.IOACT = 1'b1;
      tick();
    end else begin
      // Non-posted write waits for its own pop.
      fsb_start(1'b0, 23'h0F0040, 16'hBEEF);
      chk("n_rdy0", rdy, 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("n_wait%0d_rdy", k), rdy, 0);
        chk($sformatf("n_wait%0d_req", k), io.IOREQ, 1);
        chk($sformatf("n_wait%0d_ioa", k), io.IOA, 23'h0F0040);
      end
      io.IOACT = 1'b1;
      tick();
      chk("n_act_rdy", rdy, 0);
      io.IOACT = 1'b0;
      tick();
      chk("n_done_rdy", rdy, 1);
      chk("n_one_entry", ioempty, 1);
      chk("n_rdata_keep", rdata, 16'h0F0F);
      fsb_end();

      // One entry queued, master mid-transfer.
      fsb_start(1'b0, 23'h0F0060, 16'h0060);
      tick();
      io.IOACT = 1'b1;
      tick();
      iocs = 1'b0;
    end

    #2 nres = 1'b0;
    #1;
    chk("mr_ioreq", io.IOREQ, 0);
    chk("mr_empty", ioempty, 1);
    chk("mr_rdy", rdy, 1);
    chk("mr_ndoe", ndoe, 1);
    chk("mr_rdata", rdata, 0);
    chk("mr_ioa", io.IOA, 0);
    tick();
    nres = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_hold%0d_req", k), io.IOREQ, 0);
      chk($sformatf("mr_hold%0d_empty", k), ioempty, 1);
    end
    io.IOACT = 1'b0;
    tick();
    chk("mr_rel_empty", ioempty, 1);
    chk("mr_rel_req", io.IOREQ, 0);

    do_xfer(vecs[0], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
